// File: rtl/data_memory_arb_pkg.sv
// Shared types and constants for the two-port data memory arbiter.
package data_memory_arb_pkg;

  typedef enum logic [1:0] {
    StIdle   = 2'd0,
    StAccess = 2'd1,
    StDone   = 2'd2
  } arb_state_e;

  localparam logic PORT_CPU = 1'b0;
  localparam logic PORT_AUX = 1'b1;

  localparam int unsigned DEPTH_DEFAULT = 256;

endpackage

// File: rtl/arb_rr2.sv
// Two-way round-robin winner select; a tie goes to the port that did not win last.
module arb_rr2
  import data_memory_arb_pkg::*;
(
  input  logic [1:0] req_i,
  input  logic       last_i,
  output logic [1:0] gnt_o
);

  // One-hot grant from the request pair and the previous winner.
  always_comb begin
    gnt_o = 2'b00;
    unique case (req_i)
      2'b01:   gnt_o = 2'b01;
      2'b10:   gnt_o = 2'b10;
      2'b11:   gnt_o = (last_i == PORT_CPU) ? 2'b10 : 2'b01;
      default: gnt_o = 2'b00;
    endcase
  end

endmodule

// File: rtl/data_memory_arbiter.sv
// Arbitrates a CPU port and an aux port onto one external data memory.
// One access in flight: IDLE -> ACCESS (grant + strobe) -> DONE (completion pulse).
module data_memory_arbiter
  import data_memory_arb_pkg::*;
#(
  parameter int unsigned DEPTH = DEPTH_DEFAULT,
  parameter int unsigned AW    = 32
) (
  input  logic          Clock,
  input  logic          Reset,
  input  logic          Req0,
  input  logic          Req1,
  input  logic          We0,
  input  logic          We1,
  input  logic [AW-1:0] Addr0,
  input  logic [AW-1:0] Addr1,
  input  logic [31:0]   WData0,
  input  logic [31:0]   WData1,
  output logic          Gnt0,
  output logic          Gnt1,
  output logic          Done0,
  output logic          Done1,
  output logic          Err0,
  output logic          Err1,
  output logic [31:0]   RData0,
  output logic [31:0]   RData1,
  output logic          MemRead,
  output logic          MemWrite,
  output logic [AW-1:0] Address,
  output logic [31:0]   Write_Data,
  input  logic [31:0]   Read_Data
);

  localparam logic [AW-1:0] DepthLim = AW'(DEPTH);

  arb_state_e    state_q, state_d;
  logic          last_q, last_d;
  logic          sel_q, sel_d;
  logic          we_q, we_d;
  logic          oor_q, oor_d;
  logic [AW-1:0] addr_q, addr_d;
  logic [31:0]   wdata_q, wdata_d;
  logic          gnt0_q, gnt0_d, gnt1_q, gnt1_d;
  logic          done0_q, done0_d, done1_q, done1_d;
  logic          err0_q, err0_d, err1_q, err1_d;
  logic          rd_q, rd_d, wr_q, wr_d;
  logic [31:0]   rdata0_q, rdata0_d, rdata1_q, rdata1_d;

  logic [1:0]    win;
  logic          win_port;
  logic          req_we;
  logic [AW-1:0] req_addr;
  logic [31:0]   req_wdata;
  logic          req_oor;

  arb_rr2 u_arb (
    .req_i  ({Req1, Req0}),
    .last_i (last_q),
    .gnt_o  (win)
  );

  // Route the winning port's request fields toward the capture registers.
  always_comb begin
    win_port  = win[1];
    req_we    = win_port ? We1 : We0;
    req_addr  = win_port ? Addr1 : Addr0;
    req_wdata = win_port ? WData1 : WData0;
    req_oor   = (req_addr >= DepthLim);
  end

  // Next-state and registered-output logic for the access sequence.
  always_comb begin
    state_d  = state_q;
    last_d   = last_q;
    sel_d    = sel_q;
    we_d     = we_q;
    oor_d    = oor_q;
    addr_d   = addr_q;
    wdata_d  = wdata_q;
    rdata0_d = rdata0_q;
    rdata1_d = rdata1_q;
    gnt0_d   = 1'b0;
    gnt1_d   = 1'b0;
    done0_d  = 1'b0;
    done1_d  = 1'b0;
    err0_d   = 1'b0;
    err1_d   = 1'b0;
    rd_d     = 1'b0;
    wr_d     = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (|win) begin
          state_d = StAccess;
          last_d  = win_port;
          sel_d   = win_port;
          we_d    = req_we;
          oor_d   = req_oor;
          addr_d  = req_addr;
          wdata_d = req_wdata;
          gnt0_d  = win[0];
          gnt1_d  = win[1];
          // Out-of-range accesses still grant but never touch memory.
          rd_d    = !req_we && !req_oor;
          wr_d    = req_we && !req_oor;
        end
      end
      StAccess: begin
        state_d = StDone;
        done0_d = !sel_q;
        done1_d = sel_q;
        err0_d  = !sel_q && oor_q;
        err1_d  = sel_q && oor_q;
        if (oor_q) begin
          if (sel_q) rdata1_d = '0;
          else       rdata0_d = '0;
        end else if (!we_q) begin
          if (sel_q) rdata1_d = Read_Data;
          else       rdata0_d = Read_Data;
        end
      end
      StDone: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  // State and output registers; reset aborts any access in flight.
  always_ff @(posedge Clock) begin
    if (Reset) begin
      state_q  <= StIdle;
      last_q   <= PORT_AUX;
      sel_q    <= PORT_CPU;
      we_q     <= 1'b0;
      oor_q    <= 1'b0;
      addr_q   <= '0;
      wdata_q  <= '0;
      gnt0_q   <= 1'b0;
      gnt1_q   <= 1'b0;
      done0_q  <= 1'b0;
      done1_q  <= 1'b0;
      err0_q   <= 1'b0;
      err1_q   <= 1'b0;
      rd_q     <= 1'b0;
      wr_q     <= 1'b0;
      rdata0_q <= '0;
      rdata1_q <= '0;
    end else begin
      state_q  <= state_d;
      last_q   <= last_d;
      sel_q    <= sel_d;
      we_q     <= we_d;
      oor_q    <= oor_d;
      addr_q   <= addr_d;
      wdata_q  <= wdata_d;
      gnt0_q   <= gnt0_d;
      gnt1_q   <= gnt1_d;
      done0_q  <= done0_d;
      done1_q  <= done1_d;
      err0_q   <= err0_d;
      err1_q   <= err1_d;
      rd_q     <= rd_d;
      wr_q     <= wr_d;
      rdata0_q <= rdata0_d;
      rdata1_q <= rdata1_d;
    end
  end

  assign Gnt0       = gnt0_q;
  assign Gnt1       = gnt1_q;
  assign Done0      = done0_q;
  assign Done1      = done1_q;
  assign Err0       = err0_q;
  assign Err1       = err1_q;
  assign RData0     = rdata0_q;
  assign RData1     = rdata1_q;
  assign MemRead    = rd_q;
  assign MemWrite   = wr_q;
  assign Address    = addr_q;
  assign Write_Data = wdata_q;

endmodule

// File: tb/tb_data_memory_arbiter.sv
// Scoreboard bench: the driver predicts completions into a queue, a negedge monitor checks them.
module tb_data_memory_arbiter;

  localparam int unsigned DEPTH = 256;
  localparam int unsigned AW    = 32;

  logic          Clock = 1'b0;
  logic          Reset;
  logic          Req0, Req1, We0, We1;
  logic [AW-1:0] Addr0, Addr1;
  logic [31:0]   WData0, WData1;
  logic          Gnt0, Gnt1, Done0, Done1, Err0, Err1;
  logic [31:0]   RData0, RData1;
  logic          MemRead, MemWrite;
  logic [AW-1:0] Address;
  logic [31:0]   Write_Data, Read_Data;

  always #5 Clock = ~Clock;

  data_memory_arbiter #(.DEPTH(DEPTH), .AW(AW)) dut (
    .Clock(Clock), .Reset(Reset),
    .Req0(Req0), .Req1(Req1), .We0(We0), .We1(We1),
    .Addr0(Addr0), .Addr1(Addr1), .WData0(WData0), .WData1(WData1),
    .Gnt0(Gnt0), .Gnt1(Gnt1), .Done0(Done0), .Done1(Done1),
    .Err0(Err0), .Err1(Err1), .RData0(RData0), .RData1(RData1),
    .MemRead(MemRead), .MemWrite(MemWrite), .Address(Address),
    .Write_Data(Write_Data), .Read_Data(Read_Data)
  );

  // External memory the DUT drives.
  logic [31:0] mem [DEPTH];
  assign Read_Data = (MemRead && Address < DEPTH) ? mem[Address[7:0]] : 32'hdead_beef;
  always @(posedge Clock) if (MemWrite && Address < DEPTH) mem[Address[7:0]] <= Write_Data;

  // Reference model state.
  logic [31:0] ref_mem [DEPTH];
  logic [31:0] ref_rdata [2];
  bit          ref_last;

  typedef struct {
    bit          port;
    bit          we;
    logic [31:0] addr;
    logic [31:0] wdata;
    bit          err;
    logic [31:0] rdata;
  } exp_t;
  exp_t exp_q[$];

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int gnt_cyc = 0;
  int mem_write_cycles = 0;
  exp_t mon_e;

  always @(posedge Clock) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic fail_now(input string name, input string what);
    checks++;
    errors++;
    $display("FAIL %s: %s (cycle %0d)", name, what, cyc);
  endtask

  // Execute one access against the model in service order and queue its completion.
  task automatic model_exec(input bit port, input bit we, input logic [31:0] addr,
                            input logic [31:0] wdata);
    exp_t e;
    e.port  = port;
    e.we    = we;
    e.addr  = addr;
    e.wdata = wdata;
    e.err   = (addr >= DEPTH);
    if (e.err) begin
      ref_rdata[port] = '0;
    end else if (we) begin
      ref_mem[addr[7:0]] = wdata;
    end else begin
      ref_rdata[port] = ref_mem[addr[7:0]];
    end
    e.rdata  = ref_rdata[port];
    ref_last = port;
    exp_q.push_back(e);
  endtask

  // Monitor: per-cycle invariants plus scoreboard checks at grant and completion.
  always @(negedge Clock) begin
    check("strobe_excl", {31'b0, MemRead & MemWrite}, 0);
    check("gnt_onehot", {31'b0, Gnt0 & Gnt1}, 0);
    check("done_onehot", {31'b0, Done0 & Done1}, 0);
    check("strobe_outside_access", {31'b0, (MemRead | MemWrite) & !(Gnt0 | Gnt1)}, 0);
    check("err_unqualified", {31'b0, (Err0 & !Done0) | (Err1 & !Done1)}, 0);
    if (MemWrite) mem_write_cycles++;
    if (Gnt0 || Gnt1) begin
      gnt_cyc = cyc;
      if (exp_q.size() == 0) begin
        fail_now("unexpected_gnt", "grant with no expected access");
      end else begin
        mon_e = exp_q[0];
        check("gnt_port", {31'b0, Gnt1}, {31'b0, mon_e.port});
        check("mem_read", {31'b0, MemRead}, {31'b0, !mon_e.we && !mon_e.err});
        check("mem_write", {31'b0, MemWrite}, {31'b0, mon_e.we && !mon_e.err});
        if (!mon_e.err) check("address", Address, mon_e.addr);
        if (mon_e.we && !mon_e.err) check("write_data", Write_Data, mon_e.wdata);
      end
    end
    if (Done0 || Done1) begin
      if (exp_q.size() == 0) begin
        fail_now("unexpected_done", "completion with no expected access");
      end else begin
        mon_e = exp_q.pop_front();
        check("done_port", {31'b0, Done1}, {31'b0, mon_e.port});
        check("gnt_to_done", cyc - gnt_cyc, 1);
        check("err", {31'b0, mon_e.port ? Err1 : Err0}, {31'b0, mon_e.err});
        check("rdata", mon_e.port ? RData1 : RData0, mon_e.rdata);
      end
    end
  end

  task automatic do_reset(input int n);
    Reset = 1'b1;
    Req0  = 1'b0;
    Req1  = 1'b0;
    repeat (n) begin
      @(posedge Clock);
      #1;
    end
    Reset        = 1'b0;
    ref_last     = 1'b1;
    ref_rdata[0] = '0;
    ref_rdata[1] = '0;
  endtask

  task automatic drain();
    for (int k = 0; k < 20; k++) begin
      if (exp_q.size() == 0) break;
      @(posedge Clock);
      #1;
    end
    if (exp_q.size() != 0) begin
      fail_now("done_timeout", "expected completion never arrived");
      exp_q.delete();
    end
  endtask

  // Raise requests, predict the service order, wait for n grants, then drain.
  task automatic issue(input bit r0, input bit r1, input bit hold, input int n,
                       input bit we0, input logic [31:0] a0, input logic [31:0] d0,
                       input bit we1, input logic [31:0] a1, input logic [31:0] d1);
    int  g;
    int  first;
    bit  w;
    if (r0 && r1) begin
      for (int k = 0; k < n; k++) begin
        w = !ref_last;
        if (w) model_exec(1'b1, we1, a1, d1);
        else   model_exec(1'b0, we0, a0, d0);
      end
    end else if (r1) begin
      model_exec(1'b1, we1, a1, d1);
    end else begin
      model_exec(1'b0, we0, a0, d0);
    end
    We0 = we0; Addr0 = a0; WData0 = d0; Req0 = r0;
    We1 = we1; Addr1 = a1; WData1 = d1; Req1 = r1;
    g = 0;
    first = -1;
    for (int k = 0; k < 40; k++) begin
      @(posedge Clock);
      #1;
      if ((Gnt0 || Gnt1) && first < 0) first = k;
      if (Gnt0) begin
        g++;
        if (!hold) begin
          // Scramble the inputs after the grant: the captured access must be unaffected.
          Req0 = 1'b0; We0 = 1'($urandom); Addr0 = $urandom; WData0 = $urandom;
        end
      end
      if (Gnt1) begin
        g++;
        if (!hold) begin
          Req1 = 1'b0; We1 = 1'($urandom); Addr1 = $urandom; WData1 = $urandom;
        end
      end
      if (g >= n) begin
        Req0 = 1'b0;
        Req1 = 1'b0;
        break;
      end
    end
    if (g < n) begin
      fail_now("grant_timeout", "fewer grants than requested accesses");
      Req0 = 1'b0;
      Req1 = 1'b0;
    end
    if (!(r0 && r1)) check("req_to_gnt", first, 0);
    drain();
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] v;
    int          wc;
    bit          r0, r1, we0, we1;
    logic [31:0] a0, a1;
    int          pat;

    Req0 = 0; Req1 = 0; We0 = 0; We1 = 0;
    Addr0 = '0; Addr1 = '0; WData0 = '0; WData1 = '0;
    Reset = 1'b1;
    for (int i = 0; i < int'(DEPTH); i++) begin
      v = (i == 7) ? 32'd8 : $urandom;
      mem[i]     <= v;
      ref_mem[i]  = v;
    end

    // Reset values.
    do_reset(3);
    check("rst_gnt", {30'b0, Gnt1, Gnt0}, 0);
    check("rst_done", {30'b0, Done1, Done0}, 0);
    check("rst_err", {30'b0, Err1, Err0}, 0);
    check("rst_strobes", {30'b0, MemWrite, MemRead}, 0);
    check("rst_rdata0", RData0, 0);
    check("rst_rdata1", RData1, 0);
    check("rst_address", Address, 0);
    check("rst_write_data", Write_Data, 0);

    // Basic load from address 7.
    issue(1, 0, 0, 1, 0, 32'd7, 32'd0, 0, 32'd0, 32'd0);
    check("load7_rdata0", RData0, 32'd8);

    // Aux store then CPU load of the same word.
    wc = mem_write_cycles;
    issue(0, 1, 0, 1, 0, 32'd0, 32'd0, 1, 32'd15, 32'd15);
    check("store_write_once", mem_write_cycles - wc, 1);
    issue(1, 0, 0, 1, 0, 32'd15, 32'd0, 0, 32'd0, 32'd0);
    check("load15_rdata0", RData0, 32'd15);

    // Out-of-range load.
    wc = mem_write_cycles;
    issue(1, 0, 0, 1, 0, 32'd300, 32'd0, 0, 32'd0, 32'd0);
    check("oor_rdata0", RData0, 0);
    check("oor_no_write", mem_write_cycles - wc, 0);

    // Both held after reset: alternating service starting with port 0.
    do_reset(2);
    issue(1, 1, 1, 4, 0, 32'd3, 32'd0, 0, 32'd4, 32'd0);

    // Reset during the access cycle of a load aborts it.
    model_exec(1'b0, 1'b0, 32'd5, 32'd0);
    We0 = 0; Addr0 = 32'd5; Req0 = 1;
    @(posedge Clock);
    #1;
    check("abort_gnt0", {31'b0, Gnt0}, 1);
    Req0  = 0;
    Reset = 1;
    @(posedge Clock);
    #1;
    exp_q.delete();
    check("abort_done0", {31'b0, Done0}, 0);
    check("abort_gnt0_clr", {31'b0, Gnt0}, 0);
    check("abort_memread", {31'b0, MemRead}, 0);
    check("abort_rdata0", RData0, 0);
    check("abort_address", Address, 0);
    Reset = 0;
    ref_last = 1'b1;
    ref_rdata[0] = '0;
    ref_rdata[1] = '0;
    @(posedge Clock);
    #1;
    check("abort_no_late_done", {31'b0, Done0}, 0);

    // Randomized traffic.
    for (int t = 0; t < 80; t++) begin
      pat = $urandom_range(0, 2);
      r0  = (pat != 1);
      r1  = (pat != 0);
      we0 = 1'($urandom);
      we1 = 1'($urandom);
      a0  = ($urandom_range(0, 9) == 0) ? $urandom_range(256, 400) : $urandom_range(0, 31);
      a1  = ($urandom_range(0, 9) == 0) ? $urandom_range(256, 400) : $urandom_range(0, 31);
      issue(r0, r1, 0, (r0 && r1) ? 2 : 1, we0, a0, $urandom, we1, a1, $urandom);
    end

    repeat (3) @(posedge Clock);
    #1;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
